// File: rtl/boa_stage_id.sv
// Boa32 instruction decode stage: IF/ID register, RV32I field/immediate decode,
// illegal-opcode trap and static branch prediction (JAL, backward branches).
module boa_stage_id (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        d_valid,
    input  logic [31:1] d_pc,
    input  logic [31:0] d_insn,
    input  logic        d_trap,
    input  logic [3:0]  d_cause,
    output logic        q_valid,
    output logic [31:1] q_pc,
    output logic [31:0] q_insn,
    output logic [4:0]  q_rs1,
    output logic [4:0]  q_rs2,
    output logic [4:0]  q_rd,
    output logic [31:0] q_imm,
    output logic        q_branch_predict,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    output logic        fw_branch_predict,
    output logic [31:1] fw_branch_target,
    input  logic        fw_stall_id,
    output logic        fw_stall_if
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

    logic        r_valid;
    logic        r_trap;
    logic [31:1] r_pc;
    logic [31:0] r_insn;
    logic [3:0]  r_cause;

    // Clear only kills valid/trap; stale pc/insn are harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_trap  <= 1'b0;
            r_pc    <= '0;
            r_insn  <= '0;
            r_cause <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_trap  <= 1'b0;
        end else if (!fw_stall_id) begin
            r_valid <= d_valid;
            r_trap  <= d_trap;
            r_pc    <= d_pc;
            r_insn  <= d_insn;
            r_cause <= d_cause;
        end
    end

    logic [6:0] opcode;
    logic       fmt_u, fmt_j, fmt_i, fmt_b, fmt_s, fmt_r;
    logic       illegal;
    logic       is_jal, is_branch;
    logic       pred;

    assign opcode = r_insn[6:0];

    always_comb begin
        fmt_u = 1'b0;
        fmt_j = 1'b0;
        fmt_i = 1'b0;
        fmt_b = 1'b0;
        fmt_s = 1'b0;
        fmt_r = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:                           fmt_u = 1'b1;
            OP_JAL:                                     fmt_j = 1'b1;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_MISC,
            OP_SYSTEM:                                  fmt_i = 1'b1;
            OP_BRANCH:                                  fmt_b = 1'b1;
            OP_STORE:                                   fmt_s = 1'b1;
            OP_OP:                                      fmt_r = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = !(fmt_u || fmt_j || fmt_i || fmt_b || fmt_s || fmt_r);
    assign is_jal    = (opcode == OP_JAL);
    assign is_branch = fmt_b;

    always_comb begin
        q_imm = '0;
        if (fmt_i)
            q_imm = {{20{r_insn[31]}}, r_insn[31:20]};
        else if (fmt_s)
            q_imm = {{20{r_insn[31]}}, r_insn[31:25], r_insn[11:7]};
        else if (fmt_b)
            q_imm = {{19{r_insn[31]}}, r_insn[31], r_insn[7], r_insn[30:25], r_insn[11:8], 1'b0};
        else if (fmt_u)
            q_imm = {r_insn[31:12], 12'b0};
        else if (fmt_j)
            q_imm = {{11{r_insn[31]}}, r_insn[31], r_insn[19:12], r_insn[20], r_insn[30:21], 1'b0};
    end

    assign q_rd  = (fmt_u || fmt_j || fmt_i || fmt_r) ? r_insn[11:7]  : 5'd0;
    assign q_rs1 = (fmt_i || fmt_s || fmt_b || fmt_r) ? r_insn[19:15] : 5'd0;
    assign q_rs2 = (fmt_s || fmt_b || fmt_r)          ? r_insn[24:20] : 5'd0;

    // IF trap outranks the illegal-opcode check.
    assign q_trap  = r_trap || (r_valid && illegal);
    assign q_cause = r_trap ? r_cause : (q_trap ? CAUSE_ILLEGAL : 4'd0);
    assign q_valid = r_valid && !q_trap && !clear;

    assign q_pc   = r_pc;
    assign q_insn = r_insn;

    // Backward branch == negative offset == insn[31]; JALR never predicted.
    assign pred              = q_valid && (is_jal || (is_branch && r_insn[31]));
    assign q_branch_predict  = pred;
    assign fw_branch_predict = pred && !fw_stall_id;
    assign fw_branch_target  = r_pc + q_imm[31:1];
    assign fw_stall_if       = fw_stall_id;
endmodule

// File: tb/tb_boa_stage_id.sv
// Bench for boa_stage_id: vector table, directed corner sequences and a
// randomized run against a behavioural model of the decode stage.
module tb_boa_stage_id;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        d_valid = 1'b0;
    logic [31:1] d_pc = '0;
    logic [31:0] d_insn = '0;
    logic        d_trap = 1'b0;
    logic [3:0]  d_cause = '0;
    logic        fw_stall_id = 1'b0;
    logic        q_valid, q_branch_predict, q_trap, fw_branch_predict, fw_stall_if;
    logic [31:1] q_pc, fw_branch_target;
    logic [31:0] q_insn, q_imm;
    logic [4:0]  q_rs1, q_rs2, q_rd;
    logic [3:0]  q_cause;

    boa_stage_id dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_trap(d_trap), .d_cause(d_cause),
        .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .q_imm(q_imm),
        .q_branch_predict(q_branch_predict), .q_trap(q_trap), .q_cause(q_cause),
        .fw_branch_predict(fw_branch_predict), .fw_branch_target(fw_branch_target),
        .fw_stall_id(fw_stall_id), .fw_stall_if(fw_stall_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [30:0] pc;
        logic [31:0] insn;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        bp, trap;
        logic [3:0]  cause;
        logic        fwp;
        logic [30:0] fwt;
        logic        stall_if;
    } outs_t;

    typedef struct {
        logic [31:0] pc_byte;
        logic [31:0] insn;
        logic        trap;
        logic [3:0]  cause;
        logic        e_valid;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [31:0] e_imm;
        logic        e_bp, e_trap;
        logic [3:0]  e_cause;
        logic [30:0] e_fwt;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // behavioural model of the IF/ID register contents
    logic        m_valid = 0, m_trap = 0;
    logic [30:0] m_pc = '0;
    logic [31:0] m_insn = '0;
    logic [3:0]  m_cause = '0;

    function automatic outs_t dut_outs();
        outs_t o;
        o.valid = q_valid; o.pc = q_pc; o.insn = q_insn;
        o.rs1 = q_rs1; o.rs2 = q_rs2; o.rd = q_rd; o.imm = q_imm;
        o.bp = q_branch_predict; o.trap = q_trap; o.cause = q_cause;
        o.fwp = fw_branch_predict; o.fwt = fw_branch_target; o.stall_if = fw_stall_if;
        return o;
    endfunction

    // Format letter from the opcode table; "X" means illegal.
    function automatic byte fmt_of(input logic [31:0] insn);
        case (insn[6:0])
            7'h37, 7'h17:                      return "U";
            7'h6F:                             return "J";
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return "I";
            7'h63:                             return "B";
            7'h23:                             return "S";
            7'h33:                             return "R";
            default:                           return "X";
        endcase
    endfunction

    // Immediate assembled arithmetically from shifted/masked fields.
    function automatic logic [31:0] imm_of(input logic [31:0] insn, input byte f);
        int s;
        int u;
        s = int'(insn);
        u = 0;
        case (f)
            "I": u = s >>> 20;
            "S": u = ((s >>> 25) * 32) + int'((insn >> 7) & 32'd31);
            "B": u = ((s >>> 31) * 4096) + int'(((insn >> 7) & 1) * 2048)
                     + int'(((insn >> 25) & 63) * 32) + int'(((insn >> 8) & 15) * 2);
            "J": u = ((s >>> 31) * 1048576) + int'(((insn >> 12) & 255) * 4096)
                     + int'(((insn >> 20) & 1) * 2048) + int'(((insn >> 21) & 1023) * 2);
            "U": u = int'(insn & 32'hFFFFF000);
            default: u = 0;
        endcase
        return 32'(u);
    endfunction

    function automatic outs_t model_outs(input logic clr, input logic stl);
        outs_t o;
        byte f;
        logic [31:0] t;
        f = fmt_of(m_insn);
        o.pc = m_pc; o.insn = m_insn;
        o.imm = imm_of(m_insn, f);
        o.rd  = (f == "U" || f == "J" || f == "I" || f == "R") ? 5'((m_insn >> 7) & 31)  : 5'd0;
        o.rs1 = (f == "I" || f == "S" || f == "B" || f == "R") ? 5'((m_insn >> 15) & 31) : 5'd0;
        o.rs2 = (f == "S" || f == "B" || f == "R")             ? 5'((m_insn >> 20) & 31) : 5'd0;
        o.trap  = m_trap || (m_valid && f == "X");
        o.cause = m_trap ? m_cause : (o.trap ? 4'd2 : 4'd0);
        o.valid = m_valid && !o.trap && !clr;
        o.bp  = o.valid && (m_insn[6:0] == 7'h6F || (f == "B" && o.imm[31]));
        o.fwp = o.bp && !stl;
        t = ({1'b0, m_pc} + (o.imm >> 1)) % 32'h80000000;
        o.fwt = t[30:0];
        o.stall_if = stl;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    // One clock: check mid-cycle against the model, then advance model and DUT.
    task automatic tick(input string name);
        #4;
        check_outs(name, dut_outs(), model_outs(clear, fw_stall_id));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_trap = 0; m_pc = '0; m_insn = '0; m_cause = '0;
        end else if (clear) begin
            m_valid = 0; m_trap = 0;
        end else if (!fw_stall_id) begin
            m_valid = d_valid; m_trap = d_trap; m_pc = d_pc; m_insn = d_insn; m_cause = d_cause;
        end
        #1;
    endtask

    task automatic load(input logic [31:0] pc_byte, input logic [31:0] insn,
                        input logic trap, input logic [3:0] cause);
        d_valid = 1; d_pc = pc_byte[31:1]; d_insn = insn; d_trap = trap; d_cause = cause;
        clear = 0; fw_stall_id = 0;
        tick("load");
        d_valid = 0; d_trap = 0;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33};
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    vec_t vt [12];
    outs_t snap, zero_o;

    initial begin
        // pc, insn, trap, cause | valid rd rs1 rs2 imm bp trap cause target[31:1]
        vt[0]  = '{32'h40000000, 32'hFFF00093, 0, 4'd0, 1, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 0, 4'd0, 31'h1FFFFFFF};
        vt[1]  = '{32'h40000000, 32'h0080006F, 0, 4'd0, 1, 5'd0, 5'd0, 5'd0, 32'h00000008, 1, 0, 4'd0, 31'h20000004};
        vt[2]  = '{32'h40000010, 32'hFE000EE3, 0, 4'd0, 1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1, 0, 4'd0, 31'h20000006};
        vt[3]  = '{32'h40000020, 32'h00000000, 0, 4'd0, 0, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 1, 4'd2, 31'h20000010};
        vt[4]  = '{32'h40000030, 32'h00000013, 1, 4'd0, 0, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 1, 4'd0, 31'h20000018};
        vt[5]  = '{32'h40000040, 32'h00000000, 1, 4'hB, 0, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 1, 4'hB, 31'h20000020};
        vt[6]  = '{32'h40000050, 32'h002081B3, 0, 4'd0, 1, 5'd3, 5'd1, 5'd2, 32'h00000000, 0, 0, 4'd0, 31'h20000028};
        vt[7]  = '{32'h40000060, 32'h123452B7, 0, 4'd0, 1, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 0, 4'd0, 31'h291A2830};
        vt[8]  = '{32'h40000070, 32'h0020A423, 0, 4'd0, 1, 5'd0, 5'd1, 5'd2, 32'h00000008, 0, 0, 4'd0, 31'h2000003C};
        vt[9]  = '{32'h40000080, 32'h00209463, 0, 4'd0, 1, 5'd0, 5'd1, 5'd2, 32'h00000008, 0, 0, 4'd0, 31'h20000044};
        vt[10] = '{32'h40000090, 32'h000080E7, 0, 4'd0, 1, 5'd1, 5'd1, 5'd0, 32'h00000000, 0, 0, 4'd0, 31'h20000048};
        vt[11] = '{32'h400000A0, 32'h00000091, 0, 4'd0, 0, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 1, 4'd2, 31'h20000050};

        // reset held with IF presenting a valid JAL
        zero_o = '0;
        rst_n = 0; d_valid = 1; d_pc = 31'h20000000; d_insn = 32'h0080006F;
        tick("reset0");
        tick("reset1");
        check_outs("reset_zero", dut_outs(), zero_o);
        rst_n = 1;
        #2 check_outs("post_release_zero", dut_outs(), zero_o);
        tick("first_load");
        check_bit("first_load_valid", q_valid, 1'b1);
        d_valid = 0;
        tick("idle");

        // vector table
        for (int i = 0; i < 12; i++) begin
            outs_t e;
            load(vt[i].pc_byte, vt[i].insn, vt[i].trap, vt[i].cause);
            #2;
            e = '{valid: vt[i].e_valid, pc: vt[i].pc_byte[31:1], insn: vt[i].insn,
                  rs1: vt[i].e_rs1, rs2: vt[i].e_rs2, rd: vt[i].e_rd, imm: vt[i].e_imm,
                  bp: vt[i].e_bp, trap: vt[i].e_trap, cause: vt[i].e_cause,
                  fwp: vt[i].e_bp, fwt: vt[i].e_fwt, stall_if: 1'b0};
            check_outs($sformatf("vec%0d", i), dut_outs(), e);
            tick("vec_next");
        end

        // backward BEQ held by a 3-cycle stall: predict only in cycle 4
        load(32'h40000010, 32'hFE000EE3, 0, 4'd0);
        fw_stall_id = 1; d_valid = 1; d_insn = 32'h00000013; d_pc = 31'h7FFFFFF0;
        #2 snap = dut_outs();
        check_bit("stall_c1_fwp", fw_branch_predict, 1'b0);
        check_bit("stall_c1_bp", q_branch_predict, 1'b1);
        tick("stall_c1");
        for (int c = 2; c <= 3; c++) begin
            #2 check_outs($sformatf("stall_c%0d_stable", c), dut_outs(), snap);
            tick("stall_cn");
        end
        fw_stall_id = 0;
        #2 check_bit("stall_c4_fwp", fw_branch_predict, 1'b1);
        check_bit("stall_c4_target", fw_branch_target == 31'h20000006, 1'b1);
        tick("stall_c4");
        d_valid = 0;
        tick("stall_after");

        // clear + stall while a JAL sits in ID
        load(32'h40000000, 32'h0080006F, 0, 4'd0);
        clear = 1; fw_stall_id = 1;
        #2 check_bit("clear_qvalid", q_valid, 1'b0);
        check_bit("clear_fwp", fw_branch_predict, 1'b0);
        tick("clear_cyc");
        clear = 0; fw_stall_id = 0;
        #2 check_bit("clear_after_valid", q_valid, 1'b0);
        tick("clear_after");

        // reset asserted mid-stall
        load(32'h40000000, 32'hFFF00093, 0, 4'd0);
        fw_stall_id = 1;
        #2 rst_n = 0;
        #1 check_bit("rst_stall_valid", q_valid, 1'b0);
        check_bit("rst_stall_if", fw_stall_if, 1'b1);
        m_valid = 0; m_trap = 0; m_pc = '0; m_insn = '0; m_cause = '0;
        tick("rst_stall");
        rst_n = 1; fw_stall_id = 0;
        tick("rst_release");

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] p;
            p = $urandom();
            clear       = ($urandom_range(0, 15) == 0);
            fw_stall_id = ($urandom_range(0, 3) == 0);
            d_valid     = ($urandom_range(0, 3) != 0);
            d_trap      = ($urandom_range(0, 7) == 0);
            d_cause     = 4'($urandom_range(0, 15));
            d_pc        = p[31:1];
            d_insn      = rand_insn();
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
